// File: rtl/dm_write_arbiter_pkg.sv
// Shared constants and types for the data-memory write arbiter.
// Region bases/depths here are the defaults picked up by dm_write_arbiter.
package dm_write_arbiter_pkg;

  localparam int DM_ADDR_WIDTH = 8;
  localparam int DATA_WIDTH    = 16;

  localparam int DM_LD_BASE  = 'h00;
  localparam int DM_LD_DEPTH = 128;
  localparam int DM_TX_BASE  = 'h80;
  localparam int DM_TX_DEPTH = 128;

  localparam int STALL_W = 16;

  typedef enum logic {
    RR_LD = 1'b0,
    RR_TX = 1'b1
  } rr_e;

  // Index width for a region; a one-entry region still needs a 1-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_region_ptr.sv
// Write pointer for one data-memory region: base + wrapping index, with a
// sticky full flag raised when the last entry is accepted.
module dm_region_ptr
  import dm_write_arbiter_pkg::*;
#(
  parameter int AW    = DM_ADDR_WIDTH,
  parameter int BASE  = DM_LD_BASE,
  parameter int DEPTH = DM_LD_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_accept,
  input  logic          i_clr,
  output logic [AW-1:0] o_ptr,
  output logic          o_full
);

  localparam int            IW     = idx_width(DEPTH);
  localparam logic [IW-1:0] LAST   = IW'(DEPTH - 1);
  localparam logic [AW-1:0] BASE_A = AW'(BASE);

  logic [IW-1:0] r_idx;
  logic          r_full;

  // Clear wins over a same-cycle accept; the write itself already used r_idx.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_accept) begin
      if (r_idx == LAST) begin
        r_idx  <= '0;
        r_full <= 1'b1;
      end else begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  assign o_ptr  = BASE_A + AW'(r_idx);
  assign o_full = r_full;

endmodule

// File: rtl/dm_write_arbiter.sv
// Single write port arbiter for the PE data memory: wb > round-robin(ld, tx).
// Optional stall counters are compiled in with DM_ARB_STATS_EN.
module dm_write_arbiter
  import dm_write_arbiter_pkg::*;
#(
  parameter int AW       = DM_ADDR_WIDTH,
  parameter int DW       = DATA_WIDTH * 2,
  parameter int LD_BASE  = DM_LD_BASE,
  parameter int LD_DEPTH = DM_LD_DEPTH,
  parameter int TX_BASE  = DM_TX_BASE,
  parameter int TX_DEPTH = DM_TX_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_clr,
  output logic          ld_full,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_clr,
  output logic          tx_full,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data
`ifdef DM_ARB_STATS_EN
  ,
  output logic [STALL_W-1:0] ld_stall_cnt,
  output logic [STALL_W-1:0] tx_stall_cnt
`endif
);

  logic [AW-1:0] w_ld_ptr;
  logic [AW-1:0] w_tx_ptr;
  logic          w_ld_full;
  logic          w_tx_full;
  logic          w_ld_req;
  logic          w_tx_req;
  logic          w_ld_grant;
  logic          w_tx_grant;
  rr_e           r_rr;
  rr_e           w_rr_next;

  logic          r_wr_en;
  logic [AW-1:0] r_wr_addr;
  logic [DW-1:0] r_wr_data;

  dm_region_ptr #(
    .AW    (AW),
    .BASE  (LD_BASE),
    .DEPTH (LD_DEPTH)
  ) u_ld_ptr (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_ld_grant),
    .i_clr    (ld_clr),
    .o_ptr    (w_ld_ptr),
    .o_full   (w_ld_full)
  );

  dm_region_ptr #(
    .AW    (AW),
    .BASE  (TX_BASE),
    .DEPTH (TX_DEPTH)
  ) u_tx_ptr (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_tx_grant),
    .i_clr    (tx_clr),
    .o_ptr    (w_tx_ptr),
    .o_full   (w_tx_full)
  );

  assign w_ld_req = ld_valid & ~w_ld_full;
  assign w_tx_req = tx_valid & ~w_tx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr <= RR_LD;
    end else begin
      r_rr <= w_rr_next;
    end
  end

  // Grants double as the ready outputs; reset and wb both suppress them.
  always_comb begin
    w_ld_grant = 1'b0;
    w_tx_grant = 1'b0;
    w_rr_next  = r_rr;
    if (!rst && !wb_valid) begin
      if (w_ld_req && w_tx_req) begin
        w_ld_grant = (r_rr == RR_LD);
        w_tx_grant = (r_rr == RR_TX);
      end else begin
        w_ld_grant = w_ld_req;
        w_tx_grant = w_tx_req;
      end
    end
    if (w_ld_grant) begin
      w_rr_next = RR_TX;
    end else if (w_tx_grant) begin
      w_rr_next = RR_LD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= wb_valid | w_ld_grant | w_tx_grant;
      if (wb_valid) begin
        r_wr_addr <= wb_addr;
        r_wr_data <= wb_data;
      end else if (w_ld_grant) begin
        r_wr_addr <= w_ld_ptr;
        r_wr_data <= ld_data;
      end else if (w_tx_grant) begin
        r_wr_addr <= w_tx_ptr;
        r_wr_data <= tx_data;
      end
    end
  end

  assign ld_ready = w_ld_grant;
  assign tx_ready = w_tx_grant;
  assign ld_full  = w_ld_full;
  assign tx_full  = w_tx_full;
  assign wr_en    = r_wr_en;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

`ifdef DM_ARB_STATS_EN
  logic [STALL_W-1:0] r_ld_stall_cnt;
  logic [STALL_W-1:0] r_tx_stall_cnt;

  // A stall is a live request that lost to wb or to the round-robin.
  always_ff @(posedge clk) begin
    if (rst || ld_clr) begin
      r_ld_stall_cnt <= '0;
    end else if (w_ld_req && !w_ld_grant && (r_ld_stall_cnt != '1)) begin
      r_ld_stall_cnt <= r_ld_stall_cnt + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || tx_clr) begin
      r_tx_stall_cnt <= '0;
    end else if (w_tx_req && !w_tx_grant && (r_tx_stall_cnt != '1)) begin
      r_tx_stall_cnt <= r_tx_stall_cnt + STALL_W'(1);
    end
  end

  assign ld_stall_cnt = r_ld_stall_cnt;
  assign tx_stall_cnt = r_tx_stall_cnt;
`endif

endmodule

// File: tb/tb_dm_write_arbiter.sv
// Directed bench for dm_write_arbiter: per-cycle reference model plus
// literal checks on the logged write-address sequence.
module tb_dm_write_arbiter;

  localparam int AW       = 8;
  localparam int DW       = 32;
  localparam int LD_BASE  = 'h00;
  localparam int LD_DEPTH = 128;
  localparam int TX_BASE  = 'h80;
  localparam int TX_DEPTH = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic          ld_clr = 1'b0;
  logic          ld_full;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] tx_data = '0;
  logic          tx_clr = 1'b0;
  logic          tx_full;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`ifdef DM_ARB_STATS_EN
  logic [15:0]   ld_stall_cnt;
  logic [15:0]   tx_stall_cnt;
`endif

  dm_write_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .ld_clr   (ld_clr),
    .ld_full  (ld_full),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_clr   (tx_clr),
    .tx_full  (tx_full),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
`ifdef DM_ARB_STATS_EN
    ,
    .ld_stall_cnt (ld_stall_cnt),
    .tx_stall_cnt (tx_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: counts words written per region, not pointer registers.
  int            m_ld_n = 0;
  int            m_tx_n = 0;
  bit            m_ld_full = 1'b0;
  bit            m_tx_full = 1'b0;
  bit            m_tx_turn = 1'b0;
  bit            m_wr_en = 1'b0;
  logic [AW-1:0] m_wr_addr = '0;
  logic [DW-1:0] m_wr_data = '0;
  int            m_ld_st = 0;
  int            m_tx_st = 0;

  always @(negedge clk) begin
    bit lr, tr, e_ld, e_tx;
    lr   = ld_valid && !m_ld_full;
    tr   = tx_valid && !m_tx_full;
    e_ld = 1'b0;
    e_tx = 1'b0;
    if (!rst && !wb_valid) begin
      if (lr && tr) begin
        e_ld = !m_tx_turn;
        e_tx = m_tx_turn;
      end else begin
        e_ld = lr;
        e_tx = tr;
      end
    end

    chk("wr_en", 64'(wr_en), 64'(m_wr_en));
    chk("wr_addr", 64'(wr_addr), 64'(m_wr_addr));
    chk("wr_data", 64'(wr_data), 64'(m_wr_data));
    chk("ld_full", 64'(ld_full), 64'(m_ld_full));
    chk("tx_full", 64'(tx_full), 64'(m_tx_full));
    chk("ld_ready", 64'(ld_ready), 64'(e_ld));
    chk("tx_ready", 64'(tx_ready), 64'(e_tx));
`ifdef DM_ARB_STATS_EN
    chk("ld_stall_cnt", 64'(ld_stall_cnt), 64'(m_ld_st));
    chk("tx_stall_cnt", 64'(tx_stall_cnt), 64'(m_tx_st));
`endif

    if (wr_en === 1'b1) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end

    if (rst) begin
      m_ld_n = 0; m_tx_n = 0;
      m_ld_full = 1'b0; m_tx_full = 1'b0;
      m_tx_turn = 1'b0;
      m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
      m_ld_st = 0; m_tx_st = 0;
    end else begin
      m_wr_en = 1'b1;
      if (wb_valid) begin
        m_wr_addr = wb_addr;
        m_wr_data = wb_data;
      end else if (e_ld) begin
        m_wr_addr = AW'(LD_BASE + m_ld_n);
        m_wr_data = ld_data;
      end else if (e_tx) begin
        m_wr_addr = AW'(TX_BASE + m_tx_n);
        m_wr_data = tx_data;
      end else begin
        m_wr_en = 1'b0;
      end

      if (ld_clr) m_ld_st = 0;
      else if (lr && !e_ld && m_ld_st < 65535) m_ld_st++;
      if (tx_clr) m_tx_st = 0;
      else if (tr && !e_tx && m_tx_st < 65535) m_tx_st++;

      if (e_ld) begin
        m_ld_n++;
        if (m_ld_n == LD_DEPTH) begin m_ld_n = 0; m_ld_full = 1'b1; end
      end
      if (e_tx) begin
        m_tx_n++;
        if (m_tx_n == TX_DEPTH) begin m_tx_n = 0; m_tx_full = 1'b1; end
      end
      if (ld_clr) begin m_ld_n = 0; m_ld_full = 1'b0; end
      if (tx_clr) begin m_tx_n = 0; m_tx_full = 1'b0; end
      if (e_ld || e_tx) m_tx_turn = !m_tx_turn;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ld_valid = 1'b0; tx_valid = 1'b0; wb_valid = 1'b0;
    ld_clr = 1'b0; tx_clr = 1'b0;
    step();
    rst = 1'b0;
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [AW-1:0] exp);
    logic [AW-1:0] a;
    a = (idx < log_addr.size()) ? log_addr[idx] : 'x;
    chk(name, 64'(a), 64'(exp));
  endtask

  logic [AW-1:0] exp_seq[$];

  initial begin
    // Reset state and readiness held low during reset
    ld_valid = 1'b1; tx_valid = 1'b1;
    step();
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_tx_ready", 64'(tx_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    do_reset();

    // Load fill
    ld_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      ld_data = 32'(i);
      step();
    end
    ld_data = 32'hDEAD_0000;
    chk("fill_ld_full", 64'(ld_full), 64'd1);
    chk("fill_ld_ready", 64'(ld_ready), 64'd0);
    step();
    chk("fill_count", 64'(log_addr.size()), 64'd128);
    chk_log("fill_first", 0, 8'h00);
    chk_log("fill_last", 127, 8'h7F);
    chk("fill_last_data", 64'((log_data.size() > 127) ? log_data[127] : 'x), 64'd127);
    ld_clr = 1'b1;
    step();
    ld_clr = 1'b0;
    ld_data = 32'h5A5A_5A5A;
    #1;
    chk("clr_ld_ready", 64'(ld_ready), 64'd1);
    chk("clr_ld_full", 64'(ld_full), 64'd0);
    log_addr.delete(); log_data.delete();
    step();
    ld_valid = 1'b0;
    step();
    chk_log("clr_next_addr", 0, 8'h00);
    chk("clr_next_data", 64'((log_data.size() > 0) ? log_data[0] : 'x), 64'h5A5A_5A5A);

    // Contention from reset, then wb pre-emption mid-stream
    do_reset();
    ld_valid = 1'b1; tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_data = 32'(1000 + i); tx_data = 32'(2000 + i);
      step();
    end
    wb_valid = 1'b1; wb_addr = 8'h42; wb_data = 32'hBEEF_0042;
    #1;
    chk("wb_ld_ready", 64'(ld_ready), 64'd0);
    chk("wb_tx_ready", 64'(tx_ready), 64'd0);
    step(); step();
    wb_valid = 1'b0;
    step(); step();
    ld_valid = 1'b0; tx_valid = 1'b0;
    step(); step();
    exp_seq = '{8'h00, 8'h80, 8'h01, 8'h81, 8'h02, 8'h82, 8'h42, 8'h42, 8'h03, 8'h83};
    chk("rr_count", 64'(log_addr.size()), 64'(exp_seq.size()));
    foreach (exp_seq[k]) chk_log($sformatf("rr_seq[%0d]", k), k, exp_seq[k]);
    chk("wb_data", 64'((log_data.size() > 6) ? log_data[6] : 'x), 64'hBEEF_0042);

    // Transfer wrap and clear coincident with an accept
    do_reset();
    tx_valid = 1'b1;
    for (int i = 0; i < 128; i++) begin
      tx_data = 32'(3000 + i);
      step();
    end
    tx_valid = 1'b0;
    chk("tx_full_set", 64'(tx_full), 64'd1);
    step();
    chk("tx_count", 64'(log_addr.size()), 64'd128);
    chk_log("tx_first", 0, 8'h80);
    chk_log("tx_last", 127, 8'hFF);
    tx_clr = 1'b1;
    step();
    tx_clr = 1'b0;
    log_addr.delete(); log_data.delete();
    tx_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tx_data = 32'(4000 + i);
      tx_clr = (i == 5);
      step();
    end
    tx_clr = 1'b0; tx_valid = 1'b0;
    step(); step();
    exp_seq = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h80};
    chk("txclr_count", 64'(log_addr.size()), 64'(exp_seq.size()));
    foreach (exp_seq[k]) chk_log($sformatf("txclr_seq[%0d]", k), k, exp_seq[k]);

    // Reset while the load stream sits at 0x10
    do_reset();
    ld_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ld_data = 32'(i);
      step();
    end
    rst = 1'b1;
    #1;
    chk("midrst_ld_ready", 64'(ld_ready), 64'd0);
    step();
    rst = 1'b0;
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    ld_data = 32'd77;
    step();
    ld_valid = 1'b0;
    step();
    chk("midrst_count", 64'(log_addr.size()), 64'd17);
    chk_log("midrst_before", 15, 8'h0F);
    chk_log("midrst_after", 16, 8'h00);

`ifdef DM_ARB_STATS_EN
    do_reset();
    ld_valid = 1'b1; wb_valid = 1'b1; wb_addr = 8'h10;
    for (int i = 0; i < 5; i++) step();
    ld_valid = 1'b0; wb_valid = 1'b0;
    chk("stall_five", 64'(ld_stall_cnt), 64'd5);
    ld_clr = 1'b1;
    step();
    ld_clr = 1'b0;
    chk("stall_clr", 64'(ld_stall_cnt), 64'd0);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
